// File: rtl/regfile_pkg.sv
// Shared constants and specifier legality check for the bypassing register file.
package regfile_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 32;
  localparam logic [3:0] RNONE = 4'hF;

  // A specifier is legal if it names a real register or is the "no register" code.
  function automatic logic is_legal(input logic [31:0] spec, input int unsigned nregs);
    return (spec < nregs) || (spec == 32'(RNONE));
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, read hazards and issue stall.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS  = 8,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] dstE,
  input  logic [ADDR_W-1:0] dstM,
  input  logic [ADDR_W-1:0] rA,
  input  logic [ADDR_W-1:0] rB,
  input  logic              issValid,
  input  logic [ADDR_W-1:0] issDst,
  output logic              busyA,
  output logic              busyB,
  output logic              stall
);

  localparam logic [ADDR_W-1:0] NONE = ADDR_W'(RNONE);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busyNext;
  logic             wrE, wrM, rdOkA, rdOkB, issOk, accept;
  logic             busyBitA, busyBitB, busyBitIss;

  function automatic logic isReg(input logic [ADDR_W-1:0] s);
    return is_legal(32'(s), NREGS) && (s != NONE);
  endfunction

  always_comb begin
    wrE   = isReg(dstE);
    wrM   = isReg(dstM);
    rdOkA = isReg(rA);
    rdOkB = isReg(rB);
    issOk = isReg(issDst);
    busyBitA   = 1'b0;
    busyBitB   = 1'b0;
    busyBitIss = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (rA == ADDR_W'(i)) busyBitA = busy[i];
      if (rB == ADDR_W'(i)) busyBitB = busy[i];
      if (issDst == ADDR_W'(i)) busyBitIss = busy[i];
    end
    // A same-cycle writeback to the read register is covered by the bypass.
    busyA = busyBitA & rdOkA & ~((rA == dstE) | (rA == dstM));
    busyB = busyBitB & rdOkB & ~((rB == dstE) | (rB == dstM));
    stall = issValid & (busyA | busyB |
            (issOk & busyBitIss & ~(wrE & (issDst == dstE)) & ~(wrM & (issDst == dstM))));
    accept = issValid & ~stall & issOk;
  end

  // Clears first, then the accepted issue sets, so set wins on the same register.
  always_comb begin
    busyNext = busy;
    for (int i = 0; i < NREGS; i++) begin
      if (wrE && dstE == ADDR_W'(i)) busyNext[i] = 1'b0;
      if (wrM && dstM == ADDR_W'(i)) busyNext[i] = 1'b0;
      if (accept && issDst == ADDR_W'(i)) busyNext[i] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) busy <= '0;
    else        busy <= busyNext;
  end

endmodule

// File: rtl/regfile_bypass.sv
// Two-write, two-read register file with writeback bypass, scoreboard stall,
// debug port and sticky illegal-specifier flag.
module regfile_bypass
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREGS  = 8,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] dstE,
  input  logic [DATA_W-1:0] valE,
  input  logic [ADDR_W-1:0] dstM,
  input  logic [DATA_W-1:0] valM,
  input  logic [ADDR_W-1:0] rA,
  input  logic [ADDR_W-1:0] rB,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_dst,
  output logic              busy_a,
  output logic              busy_b,
  output logic              stall,
  input  logic [ADDR_W-1:0] dbg_sel,
  output logic [DATA_W-1:0] dbg_data,
  output logic              addr_err
);

  localparam logic [ADDR_W-1:0] NONE = ADDR_W'(RNONE);

  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] storedA, storedB, rdA, rdB;
  logic              wrE, wrM, rdOkA, rdOkB, dbgOk, anyIllegal;

  function automatic logic isReg(input logic [ADDR_W-1:0] s);
    return is_legal(32'(s), NREGS) && (s != NONE);
  endfunction

  always_comb begin
    wrE   = isReg(dstE);
    wrM   = isReg(dstM);
    rdOkA = isReg(rA);
    rdOkB = isReg(rB);
    dbgOk = isReg(dbg_sel);
    anyIllegal = !is_legal(32'(dstE), NREGS) || !is_legal(32'(dstM), NREGS) ||
                 !is_legal(32'(rA), NREGS)   || !is_legal(32'(rB), NREGS)   ||
                 (iss_valid && !is_legal(32'(iss_dst), NREGS));
  end

  always_comb begin
    storedA  = '0;
    storedB  = '0;
    dbg_data = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (rA == ADDR_W'(i)) storedA = regs[i];
      if (rB == ADDR_W'(i)) storedB = regs[i];
      if (dbgOk && dbg_sel == ADDR_W'(i)) dbg_data = regs[i];
    end
  end

  // Bypass priority mirrors write priority: M over E over storage.
  always_comb begin
    rdA = '0;
    if (rdOkA) begin
      if (wrM && rA == dstM)      rdA = valM;
      else if (wrE && rA == dstE) rdA = valE;
      else                        rdA = storedA;
    end
    rdB = '0;
    if (rdOkB) begin
      if (wrM && rB == dstM)      rdB = valM;
      else if (wrE && rB == dstE) rdB = valE;
      else                        rdB = storedB;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      valA     <= '0;
      valB     <= '0;
      addr_err <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wrM && dstM == ADDR_W'(i))      regs[i] <= valM;
        else if (wrE && dstE == ADDR_W'(i)) regs[i] <= valE;
      end
      valA <= rdA;
      valB <= rdB;
      if (anyIllegal) addr_err <= 1'b1;
    end
  end

  regfile_scoreboard #(
    .NREGS  (NREGS),
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clock    (clock),
    .reset    (reset),
    .dstE     (dstE),
    .dstM     (dstM),
    .rA       (rA),
    .rB       (rB),
    .issValid (iss_valid),
    .issDst   (iss_dst),
    .busyA    (busy_a),
    .busyB    (busy_b),
    .stall    (stall)
  );

endmodule

// File: tb/tb_regfile_bypass.sv
// Directed bench for regfile_bypass; expectations are queued by stimulus and
// consumed by a negedge monitor.
module tb_regfile_bypass;

  localparam int K_VALA = 0, K_VALB = 1, K_BUSYA = 2, K_BUSYB = 3,
                 K_STALL = 4, K_ERR = 5, K_DBG = 6;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  dstE, dstM, rA, rB, iss_dst, dbg_sel;
  logic [31:0] valE, valM, valA, valB, dbg_data;
  logic        iss_valid, busy_a, busy_b, stall, addr_err;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   done = 1'b0;

  regfile_bypass dut (
    .clock    (clock),
    .reset    (reset),
    .dstE     (dstE),
    .valE     (valE),
    .dstM     (dstM),
    .valM     (valM),
    .rA       (rA),
    .rB       (rB),
    .valA     (valA),
    .valB     (valB),
    .iss_valid(iss_valid),
    .iss_dst  (iss_dst),
    .busy_a   (busy_a),
    .busy_b   (busy_b),
    .stall    (stall),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data),
    .addr_err (addr_err)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] actual(input int kind);
    case (kind)
      K_VALA:  return valA;
      K_VALB:  return valB;
      K_BUSYA: return {31'd0, busy_a};
      K_BUSYB: return {31'd0, busy_b};
      K_STALL: return {31'd0, stall};
      K_ERR:   return {31'd0, addr_err};
      default: return dbg_data;
    endcase
  endfunction

  // Monitor: compares every queued expectation due this cycle.
  always @(negedge clock) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc < cyc) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d never checked (now %0d)",
                 q[i].name, q[i].cyc, cyc);
        q.delete(i);
      end else if (q[i].cyc == cyc) begin
        checks++;
        if (actual(q[i].kind) !== q[i].exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h (cycle %0d)",
                   q[i].name, actual(q[i].kind), q[i].exp, cyc);
        end
        q.delete(i);
      end
    end
  end

  task automatic expect_at(input int delay, input int kind, input logic [31:0] exp,
                           input string name);
    exp_t e;
    e.cyc  = cyc + delay;
    e.kind = kind;
    e.exp  = exp;
    e.name = name;
    q.push_back(e);
  endtask

  // Advance one cycle and return idle inputs, 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
    dstE = 4'hF; valE = '0; dstM = 4'hF; valM = '0;
    rA = 4'hF; rB = 4'hF; iss_valid = 1'b0; iss_dst = 4'hF; dbg_sel = 4'hF;
  endtask

  initial begin
    dstE = 4'hF; valE = '0; dstM = 4'hF; valM = '0;
    rA = 4'hF; rB = 4'hF; iss_valid = 1'b0; iss_dst = 4'hF; dbg_sel = 4'hF;

    step(); rA = 4'd0; iss_valid = 1'b1; iss_dst = 4'd0;
    expect_at(0, K_VALA, 0, "reset_valA");
    expect_at(0, K_ERR, 0, "reset_err");
    expect_at(0, K_STALL, 0, "reset_stall");
    step(); reset = 1'b1;

    // basic write / read
    step(); dstE = 4'd0; valE = 32'hABCDEF98; dstM = 4'd1; valM = 32'h7654321A;
    step(); rA = 4'd0; rB = 4'd1; dbg_sel = 4'd0;
    expect_at(0, K_DBG, 32'hABCDEF98, "dbg_r0");
    expect_at(1, K_VALA, 32'hABCDEF98, "read_r0");
    expect_at(1, K_VALB, 32'h7654321A, "read_r1");

    // bypass
    step(); dstE = 4'd2; valE = 32'h11;
    step(); dstE = 4'd2; valE = 32'h22; rA = 4'd2; dbg_sel = 4'd2;
    expect_at(0, K_DBG, 32'h11, "dbg_no_bypass");
    expect_at(1, K_VALA, 32'h22, "bypass_E");
    step(); dstE = 4'd2; valE = 32'h22; dstM = 4'd2; valM = 32'h33; rA = 4'd2;
    expect_at(1, K_VALA, 32'h33, "bypass_M_wins");
    step(); dbg_sel = 4'd2; rB = 4'd2;
    expect_at(0, K_DBG, 32'h33, "r2_M_wins");
    expect_at(1, K_VALB, 32'h33, "read_r2");

    // scoreboard
    step(); iss_valid = 1'b1; iss_dst = 4'd3;
    expect_at(0, K_STALL, 0, "issue3_nostall");
    step(); iss_valid = 1'b1; iss_dst = 4'd6; rA = 4'd3;
    expect_at(0, K_BUSYA, 1, "busyA_r3");
    expect_at(0, K_STALL, 1, "stall_r3");
    step(); dstM = 4'd3; valM = 32'h5A5A; rA = 4'd3; iss_valid = 1'b1; iss_dst = 4'd5;
    expect_at(0, K_BUSYA, 0, "busyA_resolved");
    expect_at(0, K_STALL, 0, "stall_resolved");
    expect_at(1, K_VALA, 32'h5A5A, "valA_wb_bypass");
    step(); rA = 4'd5; rB = 4'd6;
    expect_at(0, K_BUSYA, 1, "busy_r5_set");
    expect_at(0, K_BUSYB, 0, "stalled_r6_not_set");
    step(); rA = 4'd3;
    expect_at(0, K_BUSYA, 0, "busy_r3_cleared");

    // WAW
    step(); iss_valid = 1'b1; iss_dst = 4'd4;
    expect_at(0, K_STALL, 0, "issue4_nostall");
    step(); iss_valid = 1'b1; iss_dst = 4'd4;
    expect_at(0, K_STALL, 1, "waw_stall");
    step(); iss_valid = 1'b1; iss_dst = 4'd4; dstE = 4'd4; valE = 32'h77;
    expect_at(0, K_STALL, 0, "waw_resolved");
    step(); rA = 4'd4;
    expect_at(0, K_BUSYA, 1, "busy_r4_kept");
    expect_at(1, K_VALA, 32'h77, "read_r4");

    // RNONE / illegal
    step();
    expect_at(1, K_VALA, 0, "rnone_valA");
    expect_at(1, K_VALB, 0, "rnone_valB");
    expect_at(1, K_ERR, 0, "rnone_no_err");
    step(); rA = 4'd9;
    expect_at(0, K_BUSYA, 0, "illegal_not_busy");
    expect_at(1, K_VALA, 0, "illegal_valA");
    expect_at(1, K_ERR, 1, "illegal_sets_err");
    step(); dstE = 4'd12; valE = 32'hDEAD; dstM = 4'hF; valM = 32'hBEEF;
    expect_at(1, K_ERR, 1, "err_sticky");
    step(); dbg_sel = 4'd4;
    expect_at(0, K_DBG, 32'h77, "illegal_write_ignored");
    step(); dbg_sel = 4'd9;
    expect_at(0, K_DBG, 0, "dbg_illegal_zero");

    // async reset mid-operation
    step(); rA = 4'd4; rB = 4'd5; iss_valid = 1'b1; iss_dst = 4'd4;
    expect_at(0, K_STALL, 1, "pre_reset_stall");
    step(); rA = 4'd4; rB = 4'd2; iss_valid = 1'b1; iss_dst = 4'd4; dbg_sel = 4'd2;
    reset = 1'b0;
    expect_at(0, K_VALA, 0, "rst_valA");
    expect_at(0, K_VALB, 0, "rst_valB");
    expect_at(0, K_BUSYA, 0, "rst_busyA");
    expect_at(0, K_STALL, 0, "rst_stall");
    expect_at(0, K_ERR, 0, "rst_err");
    expect_at(0, K_DBG, 0, "rst_regs");
    step(); reset = 1'b1; rA = 4'd4; iss_valid = 1'b1; iss_dst = 4'd4;
    expect_at(0, K_STALL, 0, "post_rst_stall");
    expect_at(1, K_VALA, 0, "post_rst_valA");
    step(); rA = 4'd4;
    expect_at(0, K_BUSYA, 1, "post_rst_issue");

    step(); step(); step();
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d expectations left, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    done = 1'b1;
    $finish;
  end

  initial begin
    #20000;
    if (!done) begin
      $display("FAIL timeout: bench did not complete, required completion");
      $fatal(1, "timeout");
    end
  end

endmodule

// File: doc/regfile_bypass.md
Name: regfile_bypass

Overview:
- Parametrised successor to the processor register file; sits between decode and writeback.
- Two write ports (E from execute, M from memory) and two registered read ports (A, B).
- Adds write-to-read bypass, an explicit "no register" code, and a per-register scoreboard of pending writes with a decode stall output.
- Adds a debug read port and a sticky illegal-address flag.

Parameters:
- DATA_W, 32, data width of every register and value port.
- NREGS, 8, number of architectural registers (2..15).
- ADDR_W, 4, register-specifier width.
- RNONE, 4'hF, specifier meaning "no register"; never read, written or scoreboarded.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low.
- dstE  in  ADDR_W  E-port destination.
- valE  in  DATA_W  E-port write data.
- dstM  in  ADDR_W  M-port destination.
- valM  in  DATA_W  M-port write data.
- rA  in  ADDR_W  read specifier A.
- rB  in  ADDR_W  read specifier B.
- valA  out  DATA_W  registered read data A.
- valB  out  DATA_W  registered read data B.
- iss_valid  in  1  decode issues an instruction this cycle.
- iss_dst  in  ADDR_W  destination the issued instruction will write.
- busy_a  out  1  rA has an unresolved pending write.
- busy_b  out  1  rB has an unresolved pending write.
- stall  out  1  issue blocked this cycle.
- dbg_sel  in  ADDR_W  debug register select.
- dbg_data  out  DATA_W  combinational contents of dbg_sel.
- addr_err  out  1  sticky: an illegal specifier was used.

Behaviour:
- Reset (reset=0, asynchronous):
  - all registers, valA, valB, scoreboard and addr_err go to 0.
  - busy_a, busy_b and stall are therefore 0.
- Legal specifier: < NREGS, or == RNONE.
- Illegal specifier: >= NREGS and != RNONE, on any of dstE, dstM, rA, rB, or on iss_dst when iss_valid=1.
  - An illegal write or issue is ignored.
  - An illegal read returns 0.
  - Any illegal use sets addr_err on the next edge; addr_err clears only on reset.
- Writes take effect at the rising edge.
  - dstE==dstM (legal, not RNONE): the M port wins and valE is dropped.
- Reads have 1-cycle latency. valA at edge n+1 equals the register value after edge n's writes. Bypass priority for rA:
  - rA==dstM: valM.
  - else rA==dstE: valE.
  - else the stored register.
  - rA==RNONE gives valA=0 (never high-Z). rB/valB behave identically.
- Reads are not gated by stall; valA/valB update every cycle.
- Scoreboard: one bit per register, updated at the edge.
  - Clear bit dstE and bit dstM (legal, not RNONE).
  - Then set bit iss_dst if the issue is accepted (iss_valid & ~stall, legal, not RNONE).
  - Set beats clear for the same register in the same cycle.
- busy_a (combinational) = busy[rA] & rA legal & rA!=RNONE & ~(rA==dstE | rA==dstM). A writeback in the same cycle resolves the hazard through the bypass. busy_b is the same for rB.
- stall = iss_valid & (busy_a | busy_b | (iss_dst legal & iss_dst!=RNONE & busy[iss_dst] & iss_dst not written this cycle)). Two in-flight writes to the same register are never permitted.
- dbg_data = register[dbg_sel]; 0 for RNONE or illegal. No bypass. Debug reads do not set addr_err.
- Reset mid-operation: pending scoreboard bits are discarded. The first edge after release behaves like a fresh start.

Decomposition:
- Shared package regfile_pkg holds:
  - the RNONE constant.
  - the ADDR_W and DATA_W defaults.
  - the is_legal(spec, NREGS) function, used by all three blocks.
- Sub-module regfile_scoreboard: busy vector, set/clear logic, busy_a, busy_b and stall.
- Storage, bypass mux and debug port stay in the top module.

Test Plan:
- Reset held, then released. Write dstE=0/valE=32'hABCDEF98 and dstM=1/valM=32'h7654321A. Next cycle rA=0, rB=1 -> one cycle later valA=ABCDEF98, valB=7654321A.
- Same-cycle bypass: r2=0x11, then dstE=2/valE=0x22 with rA=2 -> valA=0x22 at the next edge (not 0x11). Adding dstM=2/valM=0x33 in the same cycle -> valA=0x33 and r2=0x33.
- Scoreboard: issue iss_dst=3 -> busy bit 3 set. Next cycle rA=3, iss_valid=1 -> busy_a=1, stall=1, and the issue is not accepted. Then dstM=3 arrives -> busy_a=0, stall=0 that cycle, and valA=valM next edge.
- WAW: pending write to r4, issue iss_dst=4 -> stall=1. Same cycle as dstE=4 -> no stall, and bit 4 remains set.
- RNONE/illegal:
  - rA=4'hF -> valA=0, addr_err stays 0.
  - rA=9 with NREGS=8 -> valA=0, addr_err=1 until reset.
  - dstE=12 -> no register changes.
- Async reset mid-operation: with busy bits set and registers nonzero, pull reset low between edges -> all outputs 0 immediately, stall=0 after release.
